// File: rtl/script_sequencer_pkg.sv
// Shared definitions for the script sequencer: opcodes, action function codes,
// feedback bit positions and the FSM state encoding.
package script_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ACTION = 2'b00,
    OP_WAIT   = 2'b01,
    OP_JUMP   = 2'b10,
    OP_END    = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    FUNC_GET      = 2'd0,
    FUNC_PUT      = 2'd1,
    FUNC_INTERACT = 2'd2,
    FUNC_THROW    = 2'd3
  } func_e;

  localparam logic ENABLED = 1'b1;

  localparam int FB_MOVE_READY = 2;
  localparam int FB_ACTION_ACK = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MOVE,
    ST_ACT,
    ST_ACK,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic logic is_busy(input state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

endpackage

// File: rtl/script_sequencer_timer.sv
// Loadable down-counter with a zero flag; one instance paces WAIT, another
// bounds the feedback waits in MOVE and ACK.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: flops are written with non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/script_sequencer.sv
// Script sequencer: walks a 16-bit instruction ROM and drives the action
// decoder, waiting on kitchen feedback with a bounded timeout.
module script_sequencer
  import script_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] pc,
  input  logic [15:0]       instr,
  input  logic [7:0]        feedbak_sig,
  output logic              en,
  output logic [7:0]        i_num,
  output logic [1:0]        func,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // The timeout counter is loaded with TIMEOUT-1 so that ERROR is entered
  // at the end of the TIMEOUT-th waiting cycle.
  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        i_num_q, i_num_d;
  func_e             func_q, func_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  opcode_e opcode;
  logic    move_ready, action_ack;
  logic    wait_load, wait_zero;
  logic    to_load, to_dec, to_zero;
  logic    unused_bits;

  assign opcode      = opcode_e'(instr[15:14]);
  assign move_ready  = feedbak_sig[FB_MOVE_READY];
  assign action_ack  = feedbak_sig[FB_ACTION_ACK];
  assign unused_bits = ^{instr[13:10], feedbak_sig[7:3], feedbak_sig[1]};

  assign wait_load = (state_q == ST_DECODE) && (opcode == OP_WAIT);
  assign to_load   = ((state_q == ST_DECODE) && (opcode == OP_ACTION)) || (state_q == ST_ACT);
  assign to_dec    = (state_q == ST_MOVE) || (state_q == ST_ACK);

  seq_timer #(.W(8)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .load_val (instr[7:0]),
    .dec      (state_q == ST_WAIT),
    .zero     (wait_zero)
  );

  seq_timer #(.W(TO_W)) u_timeout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TO_LOAD),
    .dec      (to_dec),
    .zero     (to_zero)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    i_num_d = i_num_q;
    func_d  = func_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_d = ST_FETCH;
            pc_d    = '0;
          end
        end
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_ACTION: begin
              i_num_d = instr[7:0];
              func_d  = func_e'(instr[9:8]);
              state_d = ST_MOVE;
            end
            OP_WAIT: state_d = ST_WAIT;
            OP_JUMP: begin
              pc_d    = instr[ADDR_W-1:0];
              state_d = ST_FETCH;
            end
            default: state_d = ST_DONE;
          endcase
        end
        // move_ready is the only bit that matters here, even if ack is also high.
        ST_MOVE: begin
          if (move_ready)   state_d = ST_ACT;
          else if (to_zero) state_d = ST_ERROR;
        end
        ST_ACT: state_d = ST_ACK;
        ST_ACK: begin
          if (action_ack) begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_FETCH;
          end else if (to_zero) begin
            state_d = ST_ERROR;
          end
        end
        ST_WAIT: begin
          if (wait_zero) begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    en_d   = (state_d inside {ST_MOVE, ST_ACT}) ? ENABLED : 1'b0;
    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      i_num_q <= '0;
      func_q  <= FUNC_GET;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      i_num_q <= i_num_d;
      func_q  <= func_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pc    = pc_q;
  assign en    = en_q;
  assign i_num = i_num_q;
  assign func  = func_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: doc/script_sequencer.md
SCRIPT_SEQUENCER -- requirements
Module: script_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: script address width.
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles allowed in any feedback-wait state before error.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle pulse; begins script execution at address 0 when IDLE or DONE/ERROR.
REQ-006 abort  input  1  level; forces IDLE on next edge from any state.
REQ-007 pc  output  ADDR_W  script ROM read address.
REQ-008 instr  input  16  script word, valid one cycle after pc changes (synchronous ROM).
REQ-009 feedbak_sig  input  8  kitchen state; bit2 = move_ready, bit0 = action_ack.
REQ-010 en  output  1  enable to action decoder.
REQ-011 i_num  output  8  target machine number to action decoder.
REQ-012 func  output  2  function code to action decoder (GET, PUT, INTERACT, THROW).
REQ-013 busy  output  1  high in every state except IDLE, DONE, ERROR.
REQ-014 done  output  1  high while in DONE.
REQ-015 err  output  1  high while in ERROR.

Function
REQ-016 Instruction: [15:14] opcode; 00 ACTION (func=[9:8], i_num=[7:0]), 01 WAIT (count=[7:0]), 10 JUMP (target=[ADDR_W-1:0]), 11 END.
REQ-017 States: IDLE, FETCH, DECODE, MOVE, ACT, ACK, WAIT, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR + start -> FETCH with pc=0; start ignored in all other states.
REQ-019 FETCH -> DECODE after exactly one cycle (ROM latency); instr sampled in DECODE.
REQ-020 DECODE ACTION: latch i_num/func, -> MOVE; en=1 from MOVE entry.
REQ-021 MOVE: en=1; when move_ready=1 -> ACT.
REQ-022 ACT: en=1 for exactly one cycle, -> ACK; en=0 in ACK.
REQ-023 ACK: on action_ack=1 -> pc+1, FETCH.
REQ-024 DECODE WAIT: load counter with count, -> WAIT; decrement per cycle; at 0 -> pc+1, FETCH; count=0 leaves WAIT on next cycle.
REQ-025 DECODE JUMP: pc=target, -> FETCH; DECODE END -> DONE.
REQ-026 pc increment wraps modulo 2^ADDR_W without error.
REQ-027 Timeout counter clears on entry to MOVE and ACK; reaching TIMEOUT without the awaited bit -> ERROR, en=0.
REQ-028 move_ready already 1 on MOVE entry: MOVE lasts exactly one cycle.
REQ-029 move_ready and action_ack both 1 in MOVE: only move_ready acted upon.
REQ-030 abort has priority over start and over every feedback event; abort in MOVE/ACT drops en same edge.
REQ-031 i_num/func hold last latched value outside ACTION; en=0 outside MOVE/ACT.
REQ-032 Execution latency per ACTION with ready feedback: FETCH, DECODE, MOVE, ACT, ACK = 5 cycles minimum.

Reset
REQ-033 rst asserted: state=IDLE, pc=0, en=0, i_num=0, func=0, busy=0, done=0, err=0, all counters 0, immediately (asynchronous).
REQ-034 rst mid-script discards progress; after release, requires new start.

Structure
REQ-035 Shared package holds opcode constants, func codes (GET, PUT, INTERACT, THROW), ENABLED, feedback bit indices, state encoding.
REQ-036 One sub-module natural: seq_timer (loadable down-counter with zero flag), instantiated for WAIT and timeout.
REQ-037 Outputs registered; no combinational path from feedbak_sig to en.

Verification
REQ-038 Script {ACTION GET m3, END}, move_ready high after 4 cycles, ack 2 cycles later -> i_num=3, func=GET, one-cycle ACT en pulse, done=1.
REQ-039 Script {WAIT 5, END} -> busy for 2+6 cycles in FETCH/DECODE/WAIT, then done.
REQ-040 Script {JUMP 0} with abort after 20 cycles -> state IDLE, en=0, busy=0 next edge.
REQ-041 ACTION with move_ready never asserted, TIMEOUT=16 -> err=1 after 16 MOVE cycles, en=0.
REQ-042 rst pulsed during ACK -> all outputs zero asynchronously; start afterwards restarts at pc=0.
REQ-043 ADDR_W=2, four ACTIONs no END, immediate feedback -> pc wraps 3->0, no err.
